// File: rtl/thermometer_ramp_encoder_pkg.sv
// Shared types and helpers for the thermometer ramp encoder.
// Jump feature (THERMO_JUMP_EN) uses lvl2therm for the one-cycle load.
package thermo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } thermo_state_t;

  // Thermometer code with lvl ones at the LSB end, saturated at width
  function automatic logic [63:0] lvl2therm(
    input int unsigned lvl,
    input int unsigned width
  );
    logic [63:0] r;
    if (lvl >= width) r = (64'd1 << width) - 64'd1;
    else r = (64'd1 << lvl) - 64'd1;
    return r;
  endfunction

endpackage

// File: rtl/thermometer_ramp_encoder_if.sv
// Level-request handshake for the thermometer ramp encoder.
// Carries the jump strobe when THERMO_JUMP_EN is defined.
interface thermometer_ramp_encoder_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int LVL_W = $clog2(DATA_WIDTH + 1);

  logic [LVL_W-1:0] levelIn;
  logic             levelValid;
  logic             levelReady;
`ifdef THERMO_JUMP_EN
  logic             jump;

  modport master (
    output levelIn, levelValid, jump,
    input  levelReady
  );
  modport slave (
    input  levelIn, levelValid, jump,
    output levelReady
  );
`else
  modport master (
    output levelIn, levelValid,
    input  levelReady
  );
  modport slave (
    input  levelIn, levelValid,
    output levelReady
  );
`endif
endinterface

// File: rtl/thermometer_ramp_encoder_step.sv
// One-bit thermometer step: shift a one in (up) or a zero in (down).
// sat flags that the step would run past an end of the code.
module thermo_step_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] code,
  input  logic         dir,
  output logic [W-1:0] next,
  output logic         sat
);

  always_comb begin
    next = code;
    sat  = 1'b0;
    if (dir) begin
      next = {code[W-2:0], 1'b1};
      sat  = &code;
    end else begin
      next = {1'b0, code[W-1:1]};
      sat  = ~|code;
    end
  end

endmodule

// File: rtl/thermometer_ramp_encoder.sv
// Binary level to thermometer code, ramping one bit per clock.
// Optional THERMO_JUMP_EN adds a one-cycle jump to the target.
module thermometer_ramp_encoder
  import thermo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  thermometer_ramp_encoder_if.slave lvl_if,
  output logic [DATA_WIDTH-1:0] codeOut,
  output logic                  busy,
  output logic                  done,
  output logic                  clamped
);

  localparam int LVL_W = $clog2(DATA_WIDTH + 1);
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(DATA_WIDTH);

  thermo_state_t         state, state_n;
  logic [DATA_WIDTH-1:0] code_q, code_n, step_code;
  logic [LVL_W-1:0]      cur_lvl, lvl_n;
  logic [LVL_W-1:0]      tgt, tgt_n, in_tgt;
  logic                  done_n, clamped_q, clamped_n;
  logic                  over, dir, sat;

  assign over   = lvl_if.levelIn > MAX_LVL;
  assign in_tgt = over ? MAX_LVL : lvl_if.levelIn;
  assign dir    = (state == RAMP_UP);

  thermo_step_unit #(.W(DATA_WIDTH)) u_step (
    .code (code_q),
    .dir  (dir),
    .next (step_code),
    .sat  (sat)
  );

`ifdef THERMO_JUMP_EN
  logic [63:0] jump_full;
  assign jump_full = lvl2therm(32'(in_tgt), DATA_WIDTH);
`endif

  always_comb begin
    state_n   = state;
    code_n    = code_q;
    lvl_n     = cur_lvl;
    tgt_n     = tgt;
    done_n    = 1'b0;
    clamped_n = clamped_q;
    unique case (state)
      IDLE: begin
        if (lvl_if.levelValid) begin
          clamped_n = over;
          tgt_n     = in_tgt;
`ifdef THERMO_JUMP_EN
          if (lvl_if.jump) begin
            code_n = jump_full[DATA_WIDTH-1:0];
            lvl_n  = in_tgt;
            done_n = 1'b1;
          end else
`endif
          if (in_tgt > cur_lvl) state_n = RAMP_UP;
          else if (in_tgt < cur_lvl) state_n = RAMP_DOWN;
          else done_n = 1'b1;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        // Never shift past either end, even if tgt were corrupt
        if (sat) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          code_n = step_code;
          lvl_n  = dir ? cur_lvl + LVL_W'(1) : cur_lvl - LVL_W'(1);
          if (lvl_n == tgt) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      code_q    <= '0;
      cur_lvl   <= '0;
      tgt       <= '0;
      done      <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state     <= state_n;
      code_q    <= code_n;
      cur_lvl   <= lvl_n;
      tgt       <= tgt_n;
      done      <= done_n;
      clamped_q <= clamped_n;
    end
  end

  assign lvl_if.levelReady = (state == IDLE) && !reset;
  assign codeOut = code_q;
  assign busy    = (state != IDLE);
  assign clamped = clamped_q;

endmodule
